// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode constant sets, sync polarity
// type and a counter-width helper used by the timing generator.
package vga_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{h: '{640, 16,  96, 48}, v: '{480, 10, 2, 33}};
    localparam vga_timing_t VGA_800x600_60 = '{h: '{800, 40, 128, 88}, v: '{600,  1, 4, 23}};

    // Counter width for values 0..n-1; never narrower than one bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap detection plus sync/active
// decode of the position it will hold after the coming clock edge.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int        ACTIVE = 640,
    parameter int        FP     = 16,
    parameter int        SYNC   = 96,
    parameter int        BP     = 48,
    parameter sync_pol_e POL    = SYNC_ACTIVE_LOW,
    localparam int       TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int       W      = width_for(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         wrap_en,
    output logic [W-1:0] pos,
    output logic         wrap,
    output logic         sync_nxt,
    output logic         active_nxt
);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);

    logic [W-1:0] pos_p0;
    logic [W-1:0] pos_nxt;
    logic         adv;
    logic         at_last;
    logic         in_sync;

    // wrap_en chains the axes: the vertical axis only moves when the
    // horizontal one wraps, the horizontal axis has it tied high.
    always_comb begin
        adv     = step & wrap_en;
        at_last = (pos_p0 == LAST);
        pos_nxt = pos_p0;
        if (adv) begin
            pos_nxt = at_last ? '0 : pos_p0 + 1'b1;
        end
        in_sync = (pos_nxt >= SYNC_START) && (pos_nxt < SYNC_END);
    end

    assign wrap       = adv & at_last;
    assign sync_nxt   = (POL == SYNC_ACTIVE_HIGH) ? in_sync : ~in_sync;
    assign active_nxt = (pos_nxt < ACT_END);
    assign pos        = pos_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_p0 <= LAST;
        end else begin
            pos_p0 <= pos_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel prescaler, chained
// horizontal/vertical counters and registered, zero-skew sync/strobe outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int  H_ACTIVE   = VGA_640x480_60.h.active,
    parameter int  H_FP       = VGA_640x480_60.h.fp,
    parameter int  H_SYNC     = VGA_640x480_60.h.sync,
    parameter int  H_BP       = VGA_640x480_60.h.bp,
    parameter int  V_ACTIVE   = VGA_640x480_60.v.active,
    parameter int  V_FP       = VGA_640x480_60.v.fp,
    parameter int  V_SYNC     = VGA_640x480_60.v.sync,
    parameter int  V_BP       = VGA_640x480_60.v.bp,
    parameter int  H_SYNC_POL = 0,
    parameter int  V_SYNC_POL = 0,
    parameter int  CLK_DIV    = 1,
    parameter int  FRAME_W    = 8,
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW         = width_for(H_TOTAL),
    localparam int VW         = width_for(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic               pix_tick,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               display_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || FRAME_W < 1) begin : g_param_check
        $error("vga_timing_gen: timing widths, CLK_DIV and FRAME_W must all be >= 1");
    end

    localparam sync_pol_e H_POL = (H_SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
    localparam sync_pol_e V_POL = (V_SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
    localparam int        PW    = width_for(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]      presc_p0;
    logic               tick;
    logic               h_wrap, v_wrap;
    logic               h_sync_nxt, v_sync_nxt;
    logic               h_act_nxt, v_act_nxt;
    logic               pix_tick_p0, line_start_p0, frame_start_p0;
    logic               display_on_p0, hsync_p0, vsync_p0;
    logic [FRAME_W-1:0] frame_cnt_p0;

    // Position advances on the same edge that raises pix_tick.
    assign tick = ena && (presc_p0 == PRESC_LAST);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (tick),
        .wrap_en    (1'b1),
        .pos        (hpos),
        .wrap       (h_wrap),
        .sync_nxt   (h_sync_nxt),
        .active_nxt (h_act_nxt)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (tick),
        .wrap_en    (h_wrap),
        .pos        (vpos),
        .wrap       (v_wrap),
        .sync_nxt   (v_sync_nxt),
        .active_nxt (v_act_nxt)
    );

    // Stage 0: levels and strobes registered from the next-position decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_p0       <= '0;
            pix_tick_p0    <= 1'b0;
            line_start_p0  <= 1'b0;
            frame_start_p0 <= 1'b0;
            display_on_p0  <= 1'b0;
            hsync_p0       <= (H_POL == SYNC_ACTIVE_LOW);
            vsync_p0       <= (V_POL == SYNC_ACTIVE_LOW);
            frame_cnt_p0   <= '1;
        end else begin
            if (ena) begin
                presc_p0 <= tick ? '0 : presc_p0 + 1'b1;
            end
            pix_tick_p0    <= tick;
            line_start_p0  <= h_wrap;
            frame_start_p0 <= v_wrap;
            display_on_p0  <= h_act_nxt & v_act_nxt;
            hsync_p0       <= h_sync_nxt;
            vsync_p0       <= v_sync_nxt;
            if (v_wrap) begin
                frame_cnt_p0 <= frame_cnt_p0 + 1'b1;
            end
        end
    end

    assign pix_tick    = pix_tick_p0;
    assign line_start  = line_start_p0;
    assign frame_start = frame_start_p0;
    assign display_on  = display_on_p0;
    assign hsync       = hsync_p0;
    assign vsync       = vsync_p0;
    assign frame_cnt   = frame_cnt_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four generator configurations run side by side against
// a position model derived from the count of pixel ticks since reset.
module tb_vga_timing_gen;

    localparam int N = 4;
    // 0: 640x480 defaults, 1: defaults with CLK_DIV=4, 2: 800x600 positive sync, 3: tiny raster
    localparam int C_HA   [N] = '{640, 640, 800, 6};
    localparam int C_HFP  [N] = '{16, 16, 40, 2};
    localparam int C_HS   [N] = '{96, 96, 128, 3};
    localparam int C_HBP  [N] = '{48, 48, 88, 2};
    localparam int C_VA   [N] = '{480, 480, 600, 4};
    localparam int C_VFP  [N] = '{10, 10, 1, 2};
    localparam int C_VS   [N] = '{2, 2, 4, 2};
    localparam int C_VBP  [N] = '{33, 33, 23, 1};
    localparam int C_HPOL [N] = '{0, 0, 1, 0};
    localparam int C_VPOL [N] = '{0, 0, 1, 1};
    localparam int C_DIV  [N] = '{1, 4, 1, 1};
    localparam int C_FW   [N] = '{8, 8, 8, 2};

    typedef struct packed {
        logic [31:0] hpos;
        logic [31:0] vpos;
        logic [31:0] frame;
        logic        pix_tick;
        logic        display_on;
        logic        hsync;
        logic        vsync;
        logic        line_start;
        logic        frame_start;
    } obs_t;

    logic clk, rst_n, ena;
    logic pt [N], dn [N], hs [N], vs [N], ls [N], fs [N];
    logic [9:0]  hp0, vp0, hp1, vp1, vp2;
    logic [10:0] hp2;
    logic [3:0]  hp3, vp3;
    logic [7:0]  fc0, fc1, fc2;
    logic [1:0]  fc3;

    obs_t   obs [N];
    obs_t   q [N][$];
    longint en_cnt [N];
    int     total, bad, cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_tick(pt[0]), .hpos(hp0), .vpos(vp0),
        .display_on(dn[0]), .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .frame_cnt(fc0)
    );

    vga_timing_gen #(.CLK_DIV(4)) u_div (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_tick(pt[1]), .hpos(hp1), .vpos(vp1),
        .display_on(dn[1]), .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .frame_cnt(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .H_SYNC_POL(1), .V_SYNC_POL(1)
    ) u_hd (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_tick(pt[2]), .hpos(hp2), .vpos(vp2),
        .display_on(dn[2]), .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]),
        .frame_start(fs[2]), .frame_cnt(fc2)
    );

    vga_timing_gen #(
        .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(0), .V_SYNC_POL(1), .FRAME_W(2)
    ) u_sm (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pix_tick(pt[3]), .hpos(hp3), .vpos(vp3),
        .display_on(dn[3]), .hsync(hs[3]), .vsync(vs[3]), .line_start(ls[3]),
        .frame_start(fs[3]), .frame_cnt(fc3)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            obs[i]             = '0;
            obs[i].pix_tick    = pt[i];
            obs[i].display_on  = dn[i];
            obs[i].hsync       = hs[i];
            obs[i].vsync       = vs[i];
            obs[i].line_start  = ls[i];
            obs[i].frame_start = fs[i];
        end
        obs[0].hpos = 32'(hp0); obs[0].vpos = 32'(vp0); obs[0].frame = 32'(fc0);
        obs[1].hpos = 32'(hp1); obs[1].vpos = 32'(vp1); obs[1].frame = 32'(fc1);
        obs[2].hpos = 32'(hp2); obs[2].vpos = 32'(vp2); obs[2].frame = 32'(fc2);
        obs[3].hpos = 32'(hp3); obs[3].vpos = 32'(vp3); obs[3].frame = 32'(fc3);
    end

    // Expected outputs after `ticks` pixel advances since reset (0 = reset state).
    function automatic obs_t model(input int i, input longint ticks, input logic tk);
        obs_t   m;
        longint ht, vt, fm, p, h, v, f;
        logic   hon, von, hpol, vpol;
        ht   = C_HA[i] + C_HFP[i] + C_HS[i] + C_HBP[i];
        vt   = C_VA[i] + C_VFP[i] + C_VS[i] + C_VBP[i];
        fm   = longint'(1) << C_FW[i];
        p    = ticks - 1 + ht * vt * fm;
        h    = p % ht;
        v    = (p / ht) % vt;
        f    = (p / (ht * vt)) % fm;
        hon  = (h >= C_HA[i] + C_HFP[i]) && (h < C_HA[i] + C_HFP[i] + C_HS[i]);
        von  = (v >= C_VA[i] + C_VFP[i]) && (v < C_VA[i] + C_VFP[i] + C_VS[i]);
        hpol = (C_HPOL[i] != 0);
        vpol = (C_VPOL[i] != 0);
        m             = '0;
        m.hpos        = 32'(h);
        m.vpos        = 32'(v);
        m.frame       = 32'(f);
        m.pix_tick    = tk;
        m.display_on  = (h < C_HA[i]) && (v < C_VA[i]);
        m.hsync       = hon ? hpol : !hpol;
        m.vsync       = von ? vpol : !vpol;
        m.line_start  = tk && (h == 0);
        m.frame_start = tk && (h == 0) && (v == 0);
        return m;
    endfunction

    // Drive ena for one clock and queue the expected post-edge outputs.
    task automatic step_clk(input logic e);
        logic tk;
        ena = e;
        for (int i = 0; i < N; i++) begin
            if (rst_n && e) en_cnt[i]++;
            tk = rst_n && e && (en_cnt[i] % C_DIV[i] == 0);
            q[i].push_back(model(i, en_cnt[i] / C_DIV[i], tk));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b0;
        for (int i = 0; i < N; i++) begin
            en_cnt[i] = 0;
            q[i].delete();
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t exp_o;
        rst_n = 1'b0;
        ena   = 1'b1;
        for (int i = 0; i < N; i++) begin
            en_cnt[i] = 0;
            q[i].delete();
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            exp_o = model(i, 0, 1'b0);
            total++;
            if (obs[i] !== exp_o) begin
                bad++;
                $display("FAIL reset_state dut%0d got=%h want=%h", i, obs[i], exp_o);
            end
        end
        rst_n = 1'b1;
        step_clk(1'b1);
        for (int i = 0; i < N; i++) begin
            exp_o = q[i].pop_front();
            total++;
            if (obs[i] !== exp_o) begin
                bad++;
                $display("FAIL sb_first dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
            end
        end
        total++;
        if ({hp0, vp0, dn[0], ls[0], fs[0], fc0, hs[0], vs[0]} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL first_clk got h=%0d v=%0d dn=%b ls=%b fs=%b fc=%0d hs=%b vs=%b want 0 0 1 1 1 0 1 1",
                     hp0, vp0, dn[0], ls[0], fs[0], fc0, hs[0], vs[0]);
        end
    endtask

    task automatic test_line();
        obs_t exp_o;
        int hs_lo = 0, hs_first = -1, hs_last = -1, ls1 = -1, ls2 = -1, dn_off_h = -1;
        do_reset();
        for (int c = 0; c < 1100; c++) begin
            step_clk(1'b1);
            for (int i = 0; i < N; i++) begin
                exp_o = q[i].pop_front();
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL sb_line dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
                end
            end
            if (hs[0] == 1'b0) begin
                hs_lo++;
                if (hs_first < 0) hs_first = int'(hp0);
                hs_last = int'(hp0);
            end
            if (ls[0]) begin
                if (ls1 < 0) ls1 = c;
                else if (ls2 < 0) ls2 = c;
            end
            if (!dn[0] && dn_off_h < 0) dn_off_h = int'(hp0);
        end
        total++;
        if (hs_lo != 96) begin bad++; $display("FAIL hsync_len got=%0d want=96", hs_lo); end
        total++;
        if (hs_first != 656 || hs_last != 751) begin
            bad++; $display("FAIL hsync_window got=%0d..%0d want=656..751", hs_first, hs_last);
        end
        total++;
        if (dn_off_h != 640) begin bad++; $display("FAIL display_off_h got=%0d want=640", dn_off_h); end
        total++;
        if (ls2 - ls1 != 800) begin bad++; $display("FAIL line_period got=%0d want=800", ls2 - ls1); end
    endtask

    task automatic test_hd();
        obs_t exp_o;
        int hs_hi = 0, hs_first = -1, hs_last = -1, hmax = 0, ls1 = -1, ls2 = -1;
        do_reset();
        for (int c = 0; c < 1100; c++) begin
            step_clk(1'b1);
            for (int i = 0; i < N; i++) begin
                exp_o = q[i].pop_front();
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL sb_hd dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
                end
            end
            if (hs[2]) begin
                hs_hi++;
                if (hs_first < 0) hs_first = int'(hp2);
                hs_last = int'(hp2);
            end
            if (int'(hp2) > hmax) hmax = int'(hp2);
            if (ls[2]) begin
                if (ls1 < 0) ls1 = c;
                else if (ls2 < 0) ls2 = c;
            end
        end
        total++;
        if (hs_hi != 128 || hs_first != 840 || hs_last != 967) begin
            bad++; $display("FAIL hd_hsync got=%0d cyc %0d..%0d want=128 840..967", hs_hi, hs_first, hs_last);
        end
        total++;
        if (hmax != 1055 || ls2 - ls1 != 1056) begin
            bad++; $display("FAIL hd_htotal got max=%0d period=%0d want=1055 1056", hmax, ls2 - ls1);
        end
    endtask

    task automatic test_clk_div();
        obs_t exp_o;
        int tick_n = 0, ls_n = 0, ls1 = -1, ls2 = -1;
        do_reset();
        for (int c = 0; c < 3300; c++) begin
            step_clk(1'b1);
            for (int i = 0; i < N; i++) begin
                exp_o = q[i].pop_front();
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL sb_div dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
                end
            end
            if (pt[1]) tick_n++;
            if (ls[1]) begin
                ls_n++;
                if (ls1 < 0) ls1 = c;
                else if (ls2 < 0) ls2 = c;
            end
        end
        total++;
        if (tick_n != 825) begin bad++; $display("FAIL div_ticks got=%0d want=825", tick_n); end
        total++;
        if (ls_n != 2 || ls2 - ls1 != 3200) begin
            bad++; $display("FAIL div_line got=%0d pulses period=%0d want=2 3200", ls_n, ls2 - ls1);
        end
    endtask

    task automatic test_ena_hold();
        obs_t exp_o;
        int guard = 0;
        do_reset();
        while (hp0 != 10'd100 && guard < 300) begin
            step_clk(1'b1);
            guard++;
            for (int i = 0; i < N; i++) begin
                exp_o = q[i].pop_front();
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL sb_ena dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
                end
            end
        end
        total++;
        if (hp0 != 10'd100) begin bad++; $display("FAIL ena_reach got=%0d want=100", hp0); end
        for (int c = 0; c < 10; c++) begin
            step_clk(1'b0);
            for (int i = 0; i < N; i++) begin
                exp_o = q[i].pop_front();
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL sb_hold dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
                end
            end
            total++;
            if (hp0 !== 10'd100 || pt[0] !== 1'b0) begin
                bad++; $display("FAIL ena_hold got h=%0d tick=%b want 100 0", hp0, pt[0]);
            end
        end
        step_clk(1'b1);
        for (int i = 0; i < N; i++) void'(q[i].pop_front());
        total++;
        if (hp0 !== 10'd101 || pt[0] !== 1'b1) begin
            bad++; $display("FAIL ena_resume got h=%0d tick=%b want 101 1", hp0, pt[0]);
        end
    endtask

    task automatic test_async_reset();
        obs_t exp_o;
        int guard = 0;
        do_reset();
        while (vp3 != 4'd2 && guard < 200) begin
            step_clk(1'b1);
            guard++;
            for (int i = 0; i < N; i++) void'(q[i].pop_front());
        end
        total++;
        if (vp3 != 4'd2) begin bad++; $display("FAIL arst_reach got=%0d want=2", vp3); end
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            en_cnt[i] = 0;
            exp_o = model(i, 0, 1'b0);
            total++;
            if (obs[i] !== exp_o) begin
                bad++;
                $display("FAIL arst_state dut%0d got=%h want=%h", i, obs[i], exp_o);
            end
        end
        #1;
        rst_n = 1'b1;
        step_clk(1'b1);
        for (int i = 0; i < N; i++) begin
            exp_o = q[i].pop_front();
            total++;
            if (obs[i] !== exp_o) begin
                bad++;
                $display("FAIL sb_arst dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
            end
        end
        total++;
        if ({hp3, vp3, fs[3], fc3} !== {4'd0, 4'd0, 1'b1, 2'd0}) begin
            bad++; $display("FAIL arst_restart got h=%0d v=%0d fs=%b fc=%0d want 0 0 1 0", hp3, vp3, fs[3], fc3);
        end
    endtask

    task automatic test_frames();
        obs_t exp_o;
        int   vs_hi = 0, vs_out = 0, vs_mid = 0, fs_n = 0, last_fs = -1;
        logic vs_prev;
        do_reset();
        vs_prev = vs[3];
        for (int c = 0; c < 478; c++) begin
            step_clk(1'b1);
            for (int i = 0; i < N; i++) begin
                exp_o = q[i].pop_front();
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL sb_frame dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
                end
            end
            if (vs[3]) begin
                vs_hi++;
                if (vp3 != 4'd6 && vp3 != 4'd7) vs_out++;
            end
            if (vs[3] != vs_prev && hp3 != 4'd0) vs_mid++;
            vs_prev = vs[3];
            if (fs[3]) begin
                total++;
                if (int'(fc3) != fs_n % 4) begin
                    bad++; $display("FAIL frame_cnt got=%0d want=%0d", fc3, fs_n % 4);
                end
                if (last_fs >= 0) begin
                    total++;
                    if (c - last_fs != 117) begin
                        bad++; $display("FAIL frame_period got=%0d want=117", c - last_fs);
                    end
                end
                last_fs = c;
                fs_n++;
            end
        end
        total++;
        if (fs_n != 5) begin bad++; $display("FAIL frame_pulses got=%0d want=5", fs_n); end
        total++;
        if (vs_hi != 104 || vs_out != 0 || vs_mid != 0) begin
            bad++; $display("FAIL vsync_window got=%0d stray=%0d midline=%0d want=104 0 0", vs_hi, vs_out, vs_mid);
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp_o;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step_clk($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                exp_o = q[i].pop_front();
                total++;
                if (obs[i] !== exp_o) begin
                    bad++;
                    $display("FAIL sb_b2b dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], exp_o);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset();
        test_line();
        test_hd();
        test_clk_div();
        test_ena_hold();
        test_async_reset();
        test_frames();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed-640x480 timing inside the TUMVGA top. It produces hsync, vsync, the active-video flag, pixel coordinates and frame/line strobes for any resolution, sync polarity and pixel-clock ratio. It sits between the tt_um top-level clock and the pixel/pattern logic, which consumes hpos/vpos/display_on and drives uo_out colour bits.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, 0 = hsync active-low, 1 = active-high
V_SYNC_POL, 0, 0 = vsync active-low, 1 = active-high
CLK_DIV, 1, clk cycles per pixel (>=1)
FRAME_W, 8, frame counter width
Derived, not overridable: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, HW = clog2(H_TOTAL), VW = clog2(V_TOTAL).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  advance enable; low freezes all state
pix_tick  output  1  one clk high when pixel position advances
hpos  output  HW  current pixel column, 0..H_TOTAL-1
vpos  output  VW  current line, 0..V_TOTAL-1
display_on  output  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
hsync  output  1  horizontal sync, polarity per H_SYNC_POL
vsync  output  1  vertical sync, polarity per V_SYNC_POL
line_start  output  1  one-clk pulse on entering hpos=0
frame_start  output  1  one-clk pulse on entering hpos=0, vpos=0
frame_cnt  output  FRAME_W  completed-frame counter

Behaviour:
- Single clock domain; all outputs registered; no combinational input-to-output path.
- Reset (async assert, sync release): prescaler=0, hpos=H_TOTAL-1, vpos=V_TOTAL-1, frame_cnt=all ones, display_on=0, pix_tick=0, line_start=0, frame_start=0, hsync/vsync at inactive level.
- Prescaler counts 0..CLK_DIV-1 only while ena=1. pix_tick is asserted in the clk cycle after the prescaler reaches CLK_DIV-1 with ena=1. With CLK_DIV=1, pix_tick=1 on every clk after an ena=1 edge.
- On each tick, hpos increments. At H_TOTAL-1, hpos wraps to 0 and vpos increments. At V_TOTAL-1 with hpos wrap, vpos wraps to 0 and frame_cnt increments modulo 2^FRAME_W. The first frame after reset therefore reads frame_cnt=0.
- hsync, vsync, display_on, line_start and frame_start update in the same clk edge as hpos/vpos, so they always describe the current position (zero skew).
- hsync is active for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC. vsync is active for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC. vsync changes only at line boundaries.
- line_start and frame_start last exactly one clk, regardless of CLK_DIV.
- ena=0: prescaler, counters and levels hold; pix_tick, line_start and frame_start are forced 0. Resuming continues from the held prescaler value.
- Reset mid-frame returns immediately to the reset values. The first tick after release enters (0,0) and pulses frame_start.
- Elaboration error if any porch, sync or active parameter < 1, if CLK_DIV < 1, or if FRAME_W < 1.

Decomposition:
- Shared package vga_pkg holds:
  - timing constant sets VGA_640x480_60 and VGA_800x600_60 (active/fp/sync/bp, both axes);
  - a sync-polarity enum;
  - a clog2-based width helper.
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal, vertical):
  - parameters ACTIVE/FP/SYNC/BP/POL;
  - inputs step and wrap-enable;
  - outputs pos, wrap, next-state sync and active decode.

Test Plan:
- Defaults, ena=1, release reset -> first clk: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1, frame_cnt=0, hsync=1, vsync=1.
- Defaults, free-run one line -> hsync=0 exactly for hpos 656..751 (96 clks); display_on=0 from hpos 640; line_start period 800 clks.
- Defaults, free-run 3 frames -> vsync=0 only for vpos 490..491 (1600 clks); frame_start period 420000 clks; frame_cnt 0,1,2. Force FRAME_W=2 -> wraps 3->0.
- CLK_DIV=4 -> pix_tick every 4th clk; hpos steps every 4 clks; line = 3200 clks; line_start still 1 clk wide.
- ena low for 10 clks at hpos=100 -> hpos holds at 100, no pix_tick; after re-enable the next tick gives 101. Async rst_n pulse at vpos=200 between clk edges -> outputs go to reset values before the next edge.
- H_SYNC_POL=1, V_SYNC_POL=1, 800x600 set -> hsync=1 for hpos 840..967, vsync=1 for vpos 601..604, H_TOTAL=1056, V_TOTAL=628.
